// File: rtl/nn_softconvnode_bp.sv
// nn_softconvnode_bp: backward pass of the stochastic soft convolution node.
// Gates the incoming sign-magnitude error stream with the activation derivative,
// forwards per-input error streams to the previous layer, and accumulates signed
// weight/bias gradient counts over an L-cycle window, handed off via valid/ack.
// Optional build macro: NN_SOFTCONVNODE_BP_SAT_EN (saturating accumulators;
// default build wraps at width W).
module nn_softconvnode_bp #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 10,
    parameter int unsigned L = 256
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             delta,
    input  logic             SIGN_delta,
    input  logic             dz,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     alpha,
    input  logic [N-1:0]     SIGN_alpha,
    input  logic             START,
    input  logic             grad_ack,
    output logic [N-1:0]     delta_back,
    output logic [N-1:0]     SIGN_delta_back,
    output logic [N*W-1:0]   grad,
    output logic [W-1:0]     grad_b,
    output logic             grad_valid,
    output logic             busy
);

    // Window counter only has to hold L-1.
    localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

`ifdef NN_SOFTCONVNODE_BP_SAT_EN
    // Symmetric limits so a gradient never takes the unbalanced most-negative code.
    localparam logic [W-1:0] ACC_MAX = W'((1 << (W - 1)) - 1);
    localparam logic [W-1:0] ACC_MIN = ~ACC_MAX + W'(1);
`endif

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         win_cnt_q, win_cnt_d;
    logic [N-1:0][W-1:0]   acc_q, acc_d;
    logic [W-1:0]          acc_b_q, acc_b_d;
    logic [N-1:0][W-1:0]   grad_q, grad_d;
    logic [W-1:0]          grad_b_q, grad_b_d;
    logic                  grad_valid_q, grad_valid_d;
    logic                  busy_q, busy_d;
    logic [N-1:0]          delta_back_q;
    logic [N-1:0]          sign_back_q;

    logic                  de;
    logic [N-1:0][W-1:0]   acc_smp;
    logic [W-1:0]          acc_b_smp;

    // One +/-1 step of a gradient counter; neg selects the direction.
    function automatic logic [W-1:0] acc_step(input logic [W-1:0] v,
                                              input logic hit,
                                              input logic neg);
        logic [W-1:0] r;
        r = v;
        if (hit) begin
`ifdef NN_SOFTCONVNODE_BP_SAT_EN
            if (neg) begin
                if (v != ACC_MIN) r = v - W'(1);
            end else begin
                if (v != ACC_MAX) r = v + W'(1);
            end
`else
            r = neg ? (v - W'(1)) : (v + W'(1));
`endif
        end
        return r;
    endfunction

    // Effective error: error magnitude gated by the activation derivative.
    assign de = delta & dz;

    // Accumulator values including the current cycle's sample.
    always_comb begin
        for (int n = 0; n < int'(N); n++) begin
            acc_smp[n] = acc_step(acc_q[n], de & a[n], SIGN_delta);
        end
        acc_b_smp = acc_step(acc_b_q, de, SIGN_delta);
    end

    // Back-propagated error streams, one register stage, state independent.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            delta_back_q <= '0;
            sign_back_q  <= '0;
        end else begin
            delta_back_q <= {N{de}} & alpha;
            sign_back_q  <= {N{SIGN_delta}} ^ SIGN_alpha;
        end
    end

    // Control state and gradient registers.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            state_q      <= S_IDLE;
            win_cnt_q    <= '0;
            acc_q        <= '0;
            acc_b_q      <= '0;
            grad_q       <= '0;
            grad_b_q     <= '0;
            grad_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            acc_b_q      <= acc_b_d;
            grad_q       <= grad_d;
            grad_b_q     <= grad_b_d;
            grad_valid_q <= grad_valid_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state and registered-output decode for IDLE / ACCUM / HOLD.
    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        acc_b_d      = acc_b_q;
        grad_d       = grad_q;
        grad_b_d     = grad_b_q;
        grad_valid_d = grad_valid_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    acc_d        = '0;
                    acc_b_d      = '0;
                    win_cnt_d    = CW'(L - 1);
                    state_d      = S_ACCUM;
                    busy_d       = 1'b1;
                    grad_valid_d = 1'b0;
                end
            end
            S_ACCUM: begin
                acc_d   = acc_smp;
                acc_b_d = acc_b_smp;
                if (win_cnt_q == '0) begin
                    // Last sample of the window goes straight into the result.
                    grad_d       = acc_smp;
                    grad_b_d     = acc_b_smp;
                    state_d      = S_HOLD;
                    busy_d       = 1'b0;
                    grad_valid_d = 1'b1;
                end else begin
                    win_cnt_d = win_cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (grad_ack) begin
                    grad_valid_d = 1'b0;
                    if (START) begin
                        // Back-to-back window without an idle cycle.
                        acc_d     = '0;
                        acc_b_d   = '0;
                        win_cnt_d = CW'(L - 1);
                        state_d   = S_ACCUM;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d      = S_IDLE;
                busy_d       = 1'b0;
                grad_valid_d = 1'b0;
            end
        endcase
    end

    assign delta_back      = delta_back_q;
    assign SIGN_delta_back = sign_back_q;
    assign grad            = grad_q;
    assign grad_b          = grad_b_q;
    assign grad_valid      = grad_valid_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_nn_softconvnode_bp.sv
// Self-checking bench for nn_softconvnode_bp: a W=10 and a W=8 instance share
// stimulus; a count-based gradient model and a stream model supply expectations.
module tb_nn_softconvnode_bp;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int W8 = 8;
    localparam int L  = 256;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic         INIT, delta, SIGN_delta, dz, START, grad_ack;
    logic [N-1:0] a, alpha, SIGN_alpha;

    logic [N-1:0]    db10, sdb10, db8, sdb8;
    logic [N*W-1:0]  g10;
    logic [N*W8-1:0] g8;
    logic [W-1:0]    gb10;
    logic [W8-1:0]   gb8;
    logic            gv10, gv8, busy10, busy8;

    nn_softconvnode_bp #(.N(N), .W(W), .L(L)) u10 (
        .CLK(CLK), .INIT(INIT), .delta(delta), .SIGN_delta(SIGN_delta), .dz(dz),
        .a(a), .alpha(alpha), .SIGN_alpha(SIGN_alpha), .START(START), .grad_ack(grad_ack),
        .delta_back(db10), .SIGN_delta_back(sdb10), .grad(g10), .grad_b(gb10),
        .grad_valid(gv10), .busy(busy10));

    nn_softconvnode_bp #(.N(N), .W(W8), .L(L)) u8 (
        .CLK(CLK), .INIT(INIT), .delta(delta), .SIGN_delta(SIGN_delta), .dz(dz),
        .a(a), .alpha(alpha), .SIGN_alpha(SIGN_alpha), .START(START), .grad_ack(grad_ack),
        .delta_back(db8), .SIGN_delta_back(sdb8), .grad(g8), .grad_b(gb8),
        .grad_valid(gv8), .busy(busy8));

    int errors = 0;
    int checks = 0;

    // Running window sums (m*) and the last completed window (l*).
    int m10[N], m8[N], mb10, mb8;
    int l10[N], l8[N], lb10, lb8;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Two's-complement bit pattern of v at width w.
    function automatic logic [63:0] bits(input int v, input int w);
        return 64'(v & ((1 << w) - 1));
    endfunction

    // Count update: +1 / -1 per qualifying sample, clamped when saturating.
    function automatic int mstep(input int v, input bit hit, input bit neg, input int w);
`ifdef NN_SOFTCONVNODE_BP_SAT_EN
        int lim;
        lim = (1 << (w - 1)) - 1;
        if (!hit) return v;
        if (neg) return (v <= -lim) ? v : v - 1;
        return (v >= lim) ? v : v + 1;
`else
        if (!hit) return v;
        return neg ? v - 1 : v + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_model();
        for (int n = 0; n < N; n++) begin m10[n] = 0; m8[n] = 0; end
        mb10 = 0; mb8 = 0;
    endtask

    // One clock: optionally fold the sample into the model, then check the streams.
    task automatic step_cyc(input bit accum);
        logic [N-1:0] exp_db, exp_sdb;
        bit de;
        de      = delta & dz;
        exp_db  = de ? alpha : '0;
        exp_sdb = {N{SIGN_delta}} ^ SIGN_alpha;
        if (accum) begin
            for (int n = 0; n < N; n++) begin
                m10[n] = mstep(m10[n], de & a[n], SIGN_delta, W);
                m8[n]  = mstep(m8[n],  de & a[n], SIGN_delta, W8);
            end
            mb10 = mstep(mb10, de, SIGN_delta, W);
            mb8  = mstep(mb8,  de, SIGN_delta, W8);
        end
        tick();
        chk("delta_back", 64'(db10), 64'(exp_db));
        chk("sign_back",  64'(sdb10), 64'(exp_sdb));
    endtask

    task automatic chk_grads(input string tag);
        for (int n = 0; n < N; n++) begin
            chk(tag, 64'(g10[n*W +: W]),  bits(l10[n], W));
            chk(tag, 64'(g8[n*W8 +: W8]), bits(l8[n], W8));
        end
        chk(tag, 64'(gb10), bits(lb10, W));
        chk(tag, 64'(gb8),  bits(lb8, W8));
    endtask

    task automatic chk_flags(input string tag, input bit exp_busy, input bit exp_gv);
        chk({tag, "_busy"}, 64'(busy10), 64'(exp_busy));
        chk({tag, "_gv"},   64'(gv10),   64'(exp_gv));
        chk({tag, "_busy8"}, 64'(busy8), 64'(exp_busy));
        chk({tag, "_gv8"},   64'(gv8),   64'(exp_gv));
    endtask

    // Per-cycle stimulus: 0 keeps levels, 1 toggles dz from 1, 2 randomizes.
    task automatic drive(input int mode, input int i);
        alpha      = N'($urandom);
        SIGN_alpha = N'($urandom);
        if (mode == 1) begin
            dz = (i % 2 == 0);
        end else if (mode == 2) begin
            delta      = 1'($urandom);
            dz         = 1'($urandom);
            SIGN_delta = 1'($urandom);
            a          = N'($urandom);
            START      = 1'($urandom);
        end
    endtask

    // Full window from a START in IDLE through to grad_valid.
    task automatic run_window(input int mode, input string tag);
        START = 1'b1;
        grad_ack = 1'b0;
        step_cyc(1'b0);
        START = 1'b0;
        clear_model();
        chk_flags({tag, "_start"}, 1'b1, 1'b0);
        for (int i = 0; i < L; i++) begin
            drive(mode, i);
            step_cyc(1'b1);
            if (i == L / 2) chk_flags({tag, "_mid"}, 1'b1, 1'b0);
        end
        START = 1'b0;
        chk_flags({tag, "_done"}, 1'b0, 1'b1);
        for (int n = 0; n < N; n++) begin l10[n] = m10[n]; l8[n] = m8[n]; end
        lb10 = mb10; lb8 = mb8;
        chk_grads({tag, "_grad"});
    endtask

    task automatic ack();
        grad_ack = 1'b1;
        step_cyc(1'b0);
        grad_ack = 1'b0;
        chk_flags("ack", 1'b0, 1'b0);
    endtask

    task automatic chk_reset(input string tag);
        chk_flags(tag, 1'b0, 1'b0);
        chk({tag, "_db"},  64'(db10),  64'd0);
        chk({tag, "_sdb"}, 64'(sdb10), 64'd0);
        for (int n = 0; n < N; n++) begin l10[n] = 0; l8[n] = 0; end
        lb10 = 0; lb8 = 0;
        chk_grads({tag, "_grad"});
    endtask

    initial begin
        // Reset held with START and an active error stream.
        INIT = 1'b0; START = 1'b1; delta = 1'b1; dz = 1'b1; SIGN_delta = 1'b0;
        a = '1; alpha = '1; SIGN_alpha = 4'b0101; grad_ack = 1'b0;
        repeat (3) tick();
        chk_reset("reset");

        INIT = 1'b1; START = 1'b0;
        repeat (5) step_cyc(1'b0);
        chk_flags("post_reset", 1'b0, 1'b0);

        // Stream path latency and sign combination.
        alpha = 4'b0011; SIGN_alpha = 4'b0010; delta = 1'b1; dz = 1'b1; SIGN_delta = 1'b1;
        tick();
        chk("stream_db",  64'(db10),  64'(4'b0011));
        chk("stream_sdb", 64'(sdb10), 64'(4'b1101));
        dz = 1'b0;
        tick();
        chk("stream_gated", 64'(db10), 64'd0);

        // Positive errors on lanes 0 and 2.
        delta = 1'b1; dz = 1'b1; SIGN_delta = 1'b0; a = 4'b0101;
        run_window(0, "pos");
        chk("pos_lane0", 64'(g10[0 +: W]), 64'd256);
        chk("pos_lane1", 64'(g10[W +: W]), 64'd0);
        chk("pos_bias",  64'(gb10), 64'd256);
        ack();

        // Negative errors, dz toggling: half the samples count.
        SIGN_delta = 1'b1; a = 4'b1111; delta = 1'b1;
        run_window(1, "neg");
        chk("neg_lane3", 64'(g10[3*W +: W]), bits(-128, W));
        chk("neg_bias",  64'(gb10), bits(-128, W));
        ack();

        // dz low throughout.
        dz = 1'b0;
        run_window(0, "dz0");
        chk("dz0_bias", 64'(gb10), 64'd0);
        ack();

        // Overflow at the narrow width.
        delta = 1'b1; dz = 1'b1; SIGN_delta = 1'b0; a = 4'b1111;
        run_window(0, "ovf");
`ifdef NN_SOFTCONVNODE_BP_SAT_EN
        chk("ovf_lane0_w8", 64'(g8[0 +: W8]), 64'd127);
        chk("ovf_bias_w8",  64'(gb8), 64'd127);
`else
        chk("ovf_lane0_w8", 64'(g8[0 +: W8]), 64'd0);
        chk("ovf_bias_w8",  64'(gb8), 64'd0);
`endif
        ack();

        // Random windows.
        run_window(2, "rnd1");
        ack();
        run_window(2, "rnd2");

        // Hold without ack: valid and grad stable, START ignored.
        for (int i = 0; i < 100; i++) begin
            drive(2, i);
            grad_ack = 1'b0;
            step_cyc(1'b0);
            chk("hold_gv", 64'(gv10), 64'd1);
        end
        chk_flags("hold_end", 1'b0, 1'b1);
        chk_grads("hold_grad");

        // ack together with START: straight into a new window.
        grad_ack = 1'b1; START = 1'b1;
        step_cyc(1'b0);
        grad_ack = 1'b0; START = 1'b0;
        chk_flags("b2b", 1'b1, 1'b0);
        clear_model();
        for (int i = 0; i < 49; i++) begin
            drive(2, i);
            step_cyc(1'b1);
            if (i == 10) chk_grads("b2b_keep");
        end

        // Reset mid-window discards everything.
        INIT = 1'b0;
        tick();
        chk_reset("mid_reset");
        INIT = 1'b1; START = 1'b0; grad_ack = 1'b0;
        repeat (5) step_cyc(1'b0);
        chk_flags("mid_reset_idle", 1'b0, 1'b0);

        // Recovery window after reset.
        run_window(2, "rnd3");
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nn_softconvnode_bp.md
Name: nn_softconvnode_bp

Overview:
- Backward-pass companion to the stochastic soft convolution node.
- Consumes the sign-magnitude error stream arriving at the node output, gated by the activation-derivative stream.
- Produces per-input back-propagated error streams toward the previous layer.
- Accumulates signed weight and bias gradient counts over a fixed L-cycle window, then presents them to the weight-update logic with a valid/ack handshake.

Parameters:
- N, 4: size of node window (number of inputs/weights).
- W, 10: width of each signed two's-complement gradient accumulator.
- L, 256: accumulation window length in clock cycles (1..2^16).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- INIT  input  1  synchronous active-low reset.
- delta  input  1  error stream magnitude bit at node output.
- SIGN_delta  input  1  error sign (1 = negative).
- dz  input  1  activation-derivative stream bit (softplus' = sigmoid of z).
- a  input  N  forward input activation stream bits.
- alpha  input  N  weight magnitude stream bits.
- SIGN_alpha  input  N  weight signs.
- START  input  1  pulse: begin a gradient window.
- grad_ack  input  1  consumer has taken grad/grad_b.
- delta_back  output  N  back-propagated error magnitude bits.
- SIGN_delta_back  output  N  back-propagated error signs.
- grad  output  N*W  weight gradients; lane n at [n*W +: W], signed.
- grad_b  output  W  bias gradient, signed.
- grad_valid  output  1  grad/grad_b valid.
- busy  output  1  high while accumulating.

Behaviour:
- Reset (INIT=0 at an edge): all outputs 0, all accumulators 0, window counter 0, state IDLE. Reset applies in any state, including mid-ACCUM and HOLD; a partial window is discarded.
- Effective error: de = delta & dz (combinational).

Stream path, independent of state, 1-cycle latency:
- delta_back[n] <= de & alpha[n].
- SIGN_delta_back[n] <= SIGN_delta ^ SIGN_alpha[n].

State machine IDLE / ACCUM / HOLD:
- IDLE: START=1 clears all accumulators, loads win_cnt = L-1, and moves to ACCUM.
- ACCUM: busy=1. Each cycle:
  - acc[n] += +1 if (de & a[n] & ~SIGN_delta), -1 if (de & a[n] & SIGN_delta), else unchanged.
  - acc_b changes the same way using de alone.
  - If win_cnt==0, sample this cycle, latch accumulators (including this sample) into grad/grad_b, and move to HOLD. Otherwise win_cnt -= 1.
  - Exactly L samples are taken. START is ignored.
- HOLD: grad_valid=1 and grad/grad_b are stable.
  - grad_ack=1: move to IDLE; grad_valid=0 next cycle.
  - grad_ack=1 together with START=1: clear accumulators, load win_cnt and move directly to ACCUM (back-to-back windows).
  - START without grad_ack is ignored.
- Timing: START at cycle 0 gives ACCUM over cycles 1..L, and grad_valid=1 from cycle L+1.
- grad/grad_b keep their last latched value in IDLE and ACCUM; they are cleared only by reset.
- Accumulator overflow policy is set by the optional feature below.

Optional Feature:
- Macro NN_SOFTCONVNODE_BP_SAT_EN.
- Defined: accumulators saturate at +(2^(W-1)-1) and -(2^(W-1)-1). An increment or decrement at the limit holds the value.
- Undefined: plain two's-complement wrap-around at width W.

Test Plan:
1. INIT=0 for 3 cycles with START=1, delta=1, dz=1 -> all outputs 0, busy=0, grad_valid=0. After INIT=1, nothing starts until a new START.
2. N=4, W=10, L=256; delta=dz=1, SIGN_delta=0, a=4'b0101; START at cycle 0 -> busy over cycles 1..256, grad_valid=1 at cycle 257, grad lanes {3,2,1,0} = {0,256,0,256}, grad_b=256.
3. Same as 2 but SIGN_delta=1, a=4'b1111, dz toggling 1,0,1,0 -> all grad lanes = -128, grad_b = -128. With dz=0 throughout -> all zero.
4. alpha=4'b0011, SIGN_alpha=4'b0010, delta=dz=1, SIGN_delta=1 at cycle k -> at cycle k+1 delta_back=4'b0011, SIGN_delta_back=4'b1101. Then dz=0 at k+1 -> delta_back=0 at k+2.
5. W=8, L=256, delta=dz=1, a all ones, SIGN_delta=0 -> with NN_SOFTCONVNODE_BP_SAT_EN grad lanes and grad_b = 127. Without it all = 0 (256 mod 256).
6. Handshake:
   - Hold grad_valid 100 cycles without ack -> grad stable and START ignored.
   - Assert grad_ack with START in the same cycle -> grad_valid=0 and busy=1 next cycle.
   - Assert INIT=0 at ACCUM cycle 50 -> IDLE, grad=0, no grad_valid.
